// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one beat-oriented memory port between an I-side refill
// requester and a D-side refill/writeback requester. A granted requester owns
// the port for a whole cache line of BEATS 64-bit beats; ties alternate.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   i_req, i_addr            I-side line request / line address
//   i_gnt, i_rvalid, i_rdata I-side ownership, read beat valid / data
//   i_done                   I-side completion pulse
//   d_req, d_we              D-side request, 1=writeback 0=refill
//   d_addr, d_wdata          D-side line address / current write beat
//   d_gnt, d_rvalid, d_rdata D-side ownership, read beat valid / data
//   d_wready, d_done         D-side write beat consumed / completion pulse
//   mem_req, mem_we          memory beat request / write enable
//   mem_addr, mem_wdata      beat byte address / write data
//   mem_ack, mem_rdata       beat accepted or returned / read data
module mem_arbiter #(
  parameter int unsigned BEATS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [63:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_wready,
  output logic        d_done,
  output logic [63:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  localparam int unsigned BW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF = $clog2(BEATS * 8);
  localparam logic [63:0] LINE_MASK = ~((64'(1) << OFF) - 64'(1));
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  logic [0:0]    state, state_nx;
  logic          owner, owner_nx;
  logic          last_owner, last_owner_nx;
  logic          we_q, we_nx;
  logic [63:0]   base_q, base_nx;
  logic [BW-1:0] beat, beat_nx;

  logic busy, beat_done, line_done, grant_d, own_i, own_d;

  assign busy      = (state == BUSY);
  assign beat_done = busy & mem_ack;
  assign line_done = beat_done & (beat == LAST_BEAT);
  assign own_i     = (owner == OWN_I);
  assign own_d     = (owner == OWN_D);
  // D wins when alone, or on a tie when I was the previous owner
  assign grant_d   = d_req & (~i_req | (last_owner == OWN_I));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_I;
      last_owner <= OWN_D;
      we_q       <= 1'b0;
      base_q     <= '0;
      beat       <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
      we_q       <= we_nx;
      base_q     <= base_nx;
      beat       <= beat_nx;
    end
  end

  // Next-state: grant in IDLE, count beats in BUSY
  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    we_nx         = we_q;
    base_nx       = base_q;
    beat_nx       = beat;
    if (state == IDLE) begin
      if (i_req | d_req) begin
        state_nx = BUSY;
        owner_nx = grant_d ? OWN_D : OWN_I;
        we_nx    = grant_d & d_we;
        base_nx  = (grant_d ? d_addr : i_addr) & LINE_MASK;
        beat_nx  = '0;
      end
    end else begin
      if (beat_done) begin
        beat_nx = beat + BW'(1);
        if (line_done) begin
          state_nx      = IDLE;
          last_owner_nx = owner;
        end
      end
    end
  end

  // Memory side: request fields come straight from registers
  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign mem_addr  = busy ? (base_q + (64'(beat) << 3)) : '0;
  assign mem_wdata = (busy & own_d) ? d_wdata : '0;

  // Requester side: ack is passed through to the owner only
  assign i_gnt    = busy & own_i;
  assign d_gnt    = busy & own_d;
  assign i_rvalid = beat_done & ~we_q & own_i;
  assign d_rvalid = beat_done & ~we_q & own_d;
  assign d_wready = beat_done & we_q & own_d;
  assign i_done   = line_done & own_i;
  assign d_done   = line_done & own_d;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter. Stimulus pushes
// the expected beat sequence of each line transfer into a queue; a monitor
// compares every cycle's port activity against the queue head.
module tb_mem_arbiter;

  localparam int unsigned BEATS = 4;
  localparam int LIMIT = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid, i_done;
  logic [63:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_wready, d_done;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  mem_arbiter #(.BEATS(BEATS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_wready(d_wready), .d_done(d_done),
    .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        d;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        last;
  } beat_t;

  beat_t q[$];
  int    passed = 0;
  int    total  = 0;
  int    mode   = 0;   // 0: ack always, 1: every 3rd cycle, 2: random
  logic  mlast  = 1'b1; // model of previous owner, 1 = D
  int    id     = 0;

  function automatic logic [63:0] rpat(input logic [63:0] a);
    return a ^ 64'hA5A5_0F0F_3C3C_9696;
  endfunction

  function automatic logic [63:0] wpat(input int tid, input int k);
    return {32'(tid), 32'(k)} ^ 64'h1234_5678_DEAD_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference: a line transfer is BEATS consecutive 8-byte beats from the aligned base
  task automatic push_txn(input logic d, input logic we, input logic [63:0] addr, input int tid);
    beat_t b;
    logic [63:0] base;
    base = addr - (addr % 64'(BEATS * 8));
    for (int k = 0; k < int'(BEATS); k++) begin
      b.d = d;
      b.we = d & we;
      b.addr = base + 64'(k * 8);
      b.wdata = wpat(tid, k);
      b.last = (k == int'(BEATS) - 1);
      q.push_back(b);
    end
  endtask

  assign mem_rdata = rpat(mem_addr);

  // Memory responder; ack changes 2ns after the edge, also while idle
  initial begin
    int cnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cnt++;
      case (mode)
        0: mem_ack = 1'b1;
        1: mem_ack = (cnt % 3 == 0);
        default: mem_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: flags = {i_gnt,d_gnt,i_rvalid,d_rvalid,d_wready,i_done,d_done}
  initial begin
    beat_t e;
    logic [6:0]  ef;
    logic [63:0] eir, edr, ea, ew;
    logic        ewe;
    forever begin
      @(negedge clk);
      ef = '0; eir = '0; edr = '0; ea = '0; ew = '0; ewe = 1'b0;
      if (!rst && mem_req) begin
        if (q.size() == 0) begin
          check("unexpected_beat", 64'(mem_req), 64'(0));
          continue;
        end
        e = q[0];
        ea = e.addr;
        ewe = e.we;
        ef[6] = ~e.d;
        ef[5] = e.d;
        ew = e.d ? d_wdata : 64'(0);
        if (mem_ack) begin
          void'(q.pop_front());
          if (e.we) begin
            ef[2] = 1'b1;
            ew = e.wdata;
          end else if (e.d) begin
            ef[3] = 1'b1;
            edr = rpat(e.addr);
          end else begin
            ef[4] = 1'b1;
            eir = rpat(e.addr);
          end
          ef[1] = e.last & ~e.d;
          ef[0] = e.last & e.d;
        end
      end else begin
        check("idle_mem_req", 64'(mem_req), 64'(0));
      end
      check("flags", 64'({i_gnt, d_gnt, i_rvalid, d_rvalid, d_wready, i_done, d_done}), 64'(ef));
      check("mem_addr", mem_addr, ea);
      check("mem_we", 64'(mem_we), 64'(ewe));
      check("mem_wdata", mem_wdata, ew);
      check("i_rdata", i_rdata, eir);
      check("d_rdata", d_rdata, edr);
    end
  end

  // I requester: holds req until done, scrambles address once granted
  task automatic run_i(input logic [63:0] addr, input int exp_lat);
    int n = 0;
    bit seen = 0;
    i_addr = addr;
    i_req = 1'b1;
    while (!seen && n < LIMIT) begin
      @(negedge clk);
      n++;
      if (i_done) seen = 1;
      else if (i_gnt) i_addr = {$urandom, $urandom};
    end
    check("i_done_seen", 64'(seen), 64'(1));
    if (exp_lat != 0) check("i_latency", 64'(n), 64'(exp_lat));
    @(posedge clk);
    #1 i_req = 1'b0;
  endtask

  // D requester: advances write data the cycle after each wready
  task automatic run_d(input logic [63:0] addr, input logic we, input int tid, input int exp_lat);
    int n = 0;
    int k = 0;
    bit seen = 0;
    d_addr = addr;
    d_we = we;
    d_wdata = wpat(tid, 0);
    d_req = 1'b1;
    while (!seen && n < LIMIT) begin
      @(negedge clk);
      n++;
      if (d_done) seen = 1;
      else begin
        if (d_gnt) d_addr = {$urandom, $urandom};
        if (d_wready) begin
          k++;
          @(posedge clk);
          #1 d_wdata = wpat(tid, k);
        end
      end
    end
    check("d_done_seen", 64'(seen), 64'(1));
    if (exp_lat != 0) check("d_latency", 64'(n), 64'(exp_lat));
    @(posedge clk);
    #1 d_req = 1'b0;
    d_we = 1'b0;
    d_wdata = '0;
  endtask

  // Both requesters raised together; order follows alternation
  task automatic run_both(input logic [63:0] ia, input logic [63:0] da, input logic we,
                          input int li, input int ld);
    id++;
    if (mlast) begin
      push_txn(1'b0, 1'b0, ia, 0);
      push_txn(1'b1, we, da, id);
      mlast = 1'b1;
    end else begin
      push_txn(1'b1, we, da, id);
      push_txn(1'b0, 1'b0, ia, 0);
      mlast = 1'b0;
    end
    fork
      run_i(ia, li);
      run_d(da, we, id, ld);
    join
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_gnt", 64'({i_gnt, d_gnt}), 64'(0));
    rst = 1'b0;

    // Tie after reset: I first, D follows with only the re-sample cycle
    run_both(64'h1000, 64'h2000, 1'b0, BEATS + 1, 2 * (BEATS + 1));
    run_both(64'h1040, 64'h2040, 1'b1, BEATS + 1, 2 * (BEATS + 1));

    // I-only line with ack every cycle
    push_txn(1'b0, 1'b0, 64'h1000, 0);
    mlast = 1'b0;
    run_i(64'h1000, BEATS + 1);

    // D writeback with wait states
    mode = 1;
    id++;
    push_txn(1'b1, 1'b1, 64'h2000, id);
    mlast = 1'b1;
    run_d(64'h2000, 1'b1, id, 0);

    // Reset in the middle of a D refill
    mode = 0;
    @(posedge clk);
    #1;
    push_txn(1'b1, 1'b0, 64'h4000, 0);
    d_addr = 64'h4000; d_we = 1'b0; d_req = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    q.delete();
    mlast = 1'b1;
    #1;
    check("abort_mem_req", 64'(mem_req), 64'(0));
    check("abort_d_done", 64'(d_done), 64'(0));
    d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push_txn(1'b0, 1'b0, 64'h3008, 0);
    mlast = 1'b0;
    run_i(64'h3008, BEATS + 1);

    // Ack held high while idle, then an unaligned I request
    repeat (4) @(posedge clk);
    #1;
    push_txn(1'b0, 1'b0, 64'h1010, 0);
    mlast = 1'b0;
    run_i(64'h1010, BEATS + 1);

    // Randomized mixes
    for (int t = 0; t < 40; t++) begin
      logic [63:0] ia, da;
      logic we;
      int scen;
      mode = $urandom_range(0, 2);
      scen = $urandom_range(0, 2);
      ia = {$urandom, $urandom};
      da = {$urandom, $urandom};
      we = 1'($urandom_range(0, 1));
      if (scen == 0) begin
        push_txn(1'b0, 1'b0, ia, 0);
        mlast = 1'b0;
        run_i(ia, 0);
      end else if (scen == 1) begin
        id++;
        push_txn(1'b1, we, da, id);
        mlast = 1'b1;
        run_d(da, we, id, 0);
      end else begin
        run_both(ia, da, we, 0, 0);
      end
    end

    repeat (3) @(posedge clk);
    check("queue_empty", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
